spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 110 +++++++++++
 tb/tb_spi_reg_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// SPI register bank: five 8-bit control registers written by edge-qualified SPI transactions.
// Optional rejected-transaction counter is built when SPI_REG_BANK_ERR_CNT_EN is defined.
module spi_reg_bank #(
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       read_write,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       valid,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] err_cnt
);

  localparam int NUM_REGS = 5;

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic       valid_q;
  logic       wr_strobe_q, wr_strobe_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic       accept;
  logic       wr_ok;

  // A level-high valid is one transaction: only its rising edge is taken.
  assign accept = valid & ~valid_q;
  assign wr_ok  = accept & read_write & (addr <= MAX_ADDR);

  // Storage is capped at address 4; higher legal addresses still strobe.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    wr_strobe_d = wr_ok;
    wr_addr_d   = wr_addr_q;
    if (wr_ok) begin
      wr_addr_d = addr;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == 7'(i)) begin
          regs_d[i] = data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small register bank lives in flops, so resetting the whole array is cheap and required.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      // valid_q resets high so a valid already present at reset release is not taken as new.
      valid_q     <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      valid_q     <= valid;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;

`ifdef SPI_REG_BANK_ERR_CNT_EN
  logic       reject;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign reject = accept & ~(read_write & (addr <= MAX_ADDR));

  // Saturating count of rejected transactions.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (reject && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank; a second instance with MAX_ADDR=8 covers
// the capped-decode range. Expectations for err_cnt follow SPI_REG_BANK_ERR_CNT_EN.
module tb_spi_reg_bank;

`ifdef SPI_REG_BANK_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       read_write;
  logic [6:0] addr;
  logic [7:0] data;
  logic       valid;

  logic [7:0] n_out_lo, n_out_hi, n_pwm_lo, n_pwm_hi, n_duty, n_err;
  logic       n_strobe;
  logic [6:0] n_waddr;
  logic [7:0] w_out_lo, w_out_hi, w_pwm_lo, w_pwm_hi, w_duty, w_err;
  logic       w_strobe;
  logic [6:0] w_waddr;

  int n_checks = 0;
  int n_errors = 0;
  int n_rej    = 0;
  int w_rej    = 0;
  int strobes;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .read_write(read_write), .addr(addr), .data(data), .valid(valid),
    .en_reg_out_7_0(n_out_lo), .en_reg_out_15_8(n_out_hi), .en_reg_pwm_7_0(n_pwm_lo),
    .en_reg_pwm_15_8(n_pwm_hi), .pwm_duty_cycle(n_duty), .wr_strobe(n_strobe),
    .wr_addr(n_waddr), .err_cnt(n_err)
  );

  spi_reg_bank #(.MAX_ADDR(7'h08)) dut_wide (
    .clk(clk), .rst_n(rst_n), .read_write(read_write), .addr(addr), .data(data), .valid(valid),
    .en_reg_out_7_0(w_out_lo), .en_reg_out_15_8(w_out_hi), .en_reg_pwm_7_0(w_pwm_lo),
    .en_reg_pwm_15_8(w_pwm_hi), .pwm_duty_cycle(w_duty), .wr_strobe(w_strobe),
    .wr_addr(w_waddr), .err_cnt(w_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_err(input int n);
    return ERR_EN ? ((n > 255) ? 8'hFF : 8'(n)) : 8'h00;
  endfunction

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    check({tag, ".out_lo"}, n_out_lo, e0);
    check({tag, ".out_hi"}, n_out_hi, e1);
    check({tag, ".pwm_lo"}, n_pwm_lo, e2);
    check({tag, ".pwm_hi"}, n_pwm_hi, e3);
    check({tag, ".duty"},   n_duty,   e4);
  endtask

  initial begin
    rst_n = 1'b0; read_write = 1'b0; addr = 7'h00; data = 8'h00; valid = 1'b0;
    repeat (3) tick();
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset.strobe", {7'b0, n_strobe}, 8'h00);
    check("reset.waddr",  {1'b0, n_waddr},  8'h00);
    check("reset.err",    n_err,            8'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single-cycle write of 0xA5 to address 0x02.
    read_write = 1'b1; addr = 7'h02; data = 8'hA5; valid = 1'b1;
    tick();
    check("wr02.strobe", {7'b0, n_strobe}, 8'h01);
    check("wr02.waddr",  {1'b0, n_waddr},  8'h02);
    check_regs("wr02", 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00);
    valid = 1'b0; data = 8'h5A;
    tick();
    check("wr02.strobe_off", {7'b0, n_strobe}, 8'h00);
    check("wr02.hold", n_pwm_lo, 8'hA5);

    // Valid held 20 cycles with inputs changing after acceptance: one write only.
    addr = 7'h04; data = 8'h80; valid = 1'b1; strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      strobes += int'(n_strobe);
      if (i == 0) begin
        addr = 7'h00; data = 8'h33;
      end
    end
    check("hold20.strobes", 8'(strobes), 8'h01);
    check("hold20.waddr", {1'b0, n_waddr}, 8'h04);
    check_regs("hold20", 8'h00, 8'h00, 8'hA5, 8'h00, 8'h80);
    valid = 1'b0;
    tick();

    // Out-of-range address is rejected by both instances.
    addr = 7'h10; data = 8'hFF; valid = 1'b1;
    tick();
    n_rej++; w_rej++;
    check("bad10.strobe", {7'b0, n_strobe}, 8'h00);
    check("bad10.waddr",  {1'b0, n_waddr},  8'h04);
    check("bad10.err",    n_err,            exp_err(n_rej));
    check("bad10.wide_err", w_err,          exp_err(w_rej));
    check_regs("bad10", 8'h00, 8'h00, 8'hA5, 8'h00, 8'h80);
    valid = 1'b0;
    tick();

    // Read transaction is rejected; then saturate the error counter.
    read_write = 1'b0; addr = 7'h00; data = 8'h5A; valid = 1'b1;
    tick();
    n_rej++; w_rej++;
    check("rd00.strobe", {7'b0, n_strobe}, 8'h00);
    check("rd00.out_lo", n_out_lo, 8'h00);
    check("rd00.err",    n_err,    exp_err(n_rej));
    valid = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
    end
    n_rej += 300; w_rej += 300;
    check("sat.err",      n_err, exp_err(n_rej));
    check("sat.wide_err", w_err, exp_err(w_rej));
    check_regs("sat", 8'h00, 8'h00, 8'hA5, 8'h00, 8'h80);

    // Back-to-back writes separated by a single low cycle.
    read_write = 1'b1; addr = 7'h00; data = 8'h11; valid = 1'b1; strobes = 0;
    tick();
    strobes += int'(n_strobe);
    valid = 1'b0;
    tick();
    strobes += int'(n_strobe);
    addr = 7'h01; data = 8'h22; valid = 1'b1;
    tick();
    strobes += int'(n_strobe);
    check("b2b.waddr", {1'b0, n_waddr}, 8'h01);
    valid = 1'b0;
    tick();
    strobes += int'(n_strobe);
    check("b2b.strobes", 8'(strobes), 8'h02);
    check_regs("b2b", 8'h11, 8'h22, 8'hA5, 8'h00, 8'h80);

    // Address 6: legal for the wide instance (strobe, no storage), rejected by the default one.
    addr = 7'h06; data = 8'h77; valid = 1'b1;
    tick();
    n_rej++;
    check("a06.strobe",      {7'b0, n_strobe}, 8'h00);
    check("a06.err",         n_err,            exp_err(n_rej));
    check("a06.wide_strobe", {7'b0, w_strobe}, 8'h01);
    check("a06.wide_waddr",  {1'b0, w_waddr},  8'h06);
    check("a06.wide_err",    w_err,            exp_err(w_rej));
    check("a06.wide_out_lo", w_out_lo, 8'h11);
    check("a06.wide_duty",   w_duty,   8'h80);
    valid = 1'b0;
    tick();

    // Reset while a strobe is in flight, then release with valid already high.
    addr = 7'h03; data = 8'h99; valid = 1'b1;
    tick();
    check("mid.strobe_pre", {7'b0, n_strobe}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid.strobe_rst", {7'b0, n_strobe}, 8'h00);
    check("mid.waddr",      {1'b0, n_waddr},  8'h00);
    check("mid.err",        n_err,            8'h00);
    check_regs("mid", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    n_rej = 0; w_rej = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobes += int'(n_strobe);
    end
    check("rel.strobes", 8'(strobes), 8'h00);
    check("rel.pwm_hi",  n_pwm_hi,    8'h00);
    valid = 1'b0;
    tick();
    valid = 1'b1;
    tick();
    check("rel.strobe_new", {7'b0, n_strobe}, 8'h01);
    check_regs("rel", 8'h00, 8'h00, 8'h00, 8'h99, 8'h00);
    check("rel.err", n_err, exp_err(n_rej));
    valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
